// File: rtl/regfile_access_arbiter.sv
// Two-requester arbiter that serialises write / dual-read transactions onto a
// registered-read 32x32 register file and returns a one-cycle response pulse.
module regfile_access_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_ra1,
  input  logic [2*ADDR_W-1:0] req_ra2,
  input  logic [2*ADDR_W-1:0] req_wa,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata1,
  output logic [DATA_W-1:0]   rsp_rdata2,
  output logic                busy,
  output logic [ADDR_W-1:0]   rf_read_reg1,
  output logic [ADDR_W-1:0]   rf_read_reg2,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                rf_reg_write,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state_q, state_d;
  logic   last_grant;
  logic   gnt_idx;
  logic   is_wr;

  logic [1:0]        grant;
  logic              win_idx;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_ra1, sel_ra2, sel_wa;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic wr_enable(input logic we, input logic [ADDR_W-1:0] wa);
    return we && !((ZERO_REG != 0) && (wa == '0));
  endfunction

  function automatic logic [DATA_W-1:0] rd_mask(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] d);
    return ((ZERO_REG != 0) && (a == '0)) ? '0 : d;
  endfunction

  // Arbitration: only live in IDLE; on a round-robin tie the requester that
  // did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      if (FIXED_PRIO != 0) begin
        grant[0] = req_valid[0];
        grant[1] = req_valid[1] & ~req_valid[0];
      end else begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = last_grant ? 2'b01 : 2'b10;
          default: grant = 2'b00;
        endcase
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign win_idx   = grant[1];

  always_comb begin
    sel_we    = win_idx ? req_we[1] : req_we[0];
    sel_ra1   = win_idx ? req_ra1[2*ADDR_W-1:ADDR_W] : req_ra1[ADDR_W-1:0];
    sel_ra2   = win_idx ? req_ra2[2*ADDR_W-1:ADDR_W] : req_ra2[ADDR_W-1:0];
    sel_wa    = win_idx ? req_wa[2*ADDR_W-1:ADDR_W]  : req_wa[ADDR_W-1:0];
    sel_wdata = win_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = is_wr ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output register clears on reset, so an in-flight transaction is
  // simply abandoned without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant    <= 1'b1;
      gnt_idx       <= 1'b0;
      is_wr         <= 1'b0;
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
      rsp_rdata1    <= '0;
      rsp_rdata2    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rf_read_reg1  <= sel_ra1;
            rf_read_reg2  <= sel_ra2;
            rf_write_reg  <= sel_wa;
            rf_write_data <= sel_wdata;
            rf_reg_write  <= wr_enable(sel_we, sel_wa);
            is_wr         <= sel_we;
            gnt_idx       <= win_idx;
            last_grant    <= win_idx;
            rsp_rdata1    <= '0;
            rsp_rdata2    <= '0;
          end
        end
        ISSUE: rf_reg_write <= 1'b0;
        // Register-file read data is valid in this cycle; address registers
        // still hold the request so the r0 substitution can use them.
        CAPTURE: begin
          rsp_rdata1 <= rd_mask(rf_read_reg1, rf_read_data1);
          rsp_rdata2 <= rd_mask(rf_read_reg2, rf_read_data2);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Sequences and shares the 32x32 MIPS register file between two requesters: requester 0 (core control) and requester 1 (debug/loader port).
- The register file performs either one write or one dual read per clock edge, never both, and its read data is registered. This block serialises requests, drives the register-file control and address inputs from registers, captures read data, and returns a one-cycle response to the granted requester.
- Sits between the control unit / debug port and the register file in the non-pipelined datapath.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- FIXED_PRIO, 0: 0 selects round-robin arbitration; 1 selects fixed priority, with requester 0 always winning.
- ZERO_REG, 1: 1 suppresses writes to address 0 and forces reads of address 0 to return 0.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a request transfers when valid and ready are both high on a clock edge.
- req_we  in  2  per-requester request type: 1 = write, 0 = dual read.
- req_ra1  in  2*ADDR_W  read address 1; bits [i*ADDR_W +: ADDR_W] belong to requester i.
- req_ra2  in  2*ADDR_W  read address 2, packed the same way.
- req_wa  in  2*ADDR_W  write address, packed the same way.
- req_wdata  in  2*DATA_W  write data, packed per requester.
- rsp_valid  out  2  one-hot, one-cycle completion pulse to the granted requester.
- rsp_rdata1  out  DATA_W  read data 1; valid only while rsp_valid is non-zero.
- rsp_rdata2  out  DATA_W  read data 2; valid only while rsp_valid is non-zero.
- busy  out  1  high in every state except IDLE.
- rf_read_reg1  out  ADDR_W  to register file read_reg1; registered.
- rf_read_reg2  out  ADDR_W  to register file read_reg2; registered.
- rf_write_reg  out  ADDR_W  to register file write_reg; registered.
- rf_write_data  out  DATA_W  to register file write_data; registered.
- rf_reg_write  out  1  to register file reg_write; registered.
- rf_read_data1  in  DATA_W  from register file read_data1.
- rf_read_data2  in  DATA_W  from register file read_data2.

Behaviour:
- Reset (rst_n low at an edge):
  - state goes to IDLE.
  - All outputs go to 0: rf_* outputs, rsp_valid, rsp_rdata1/2, busy.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - Any in-flight transaction is dropped and no response is produced.
  - An rf write registered before the reset edge is still performed by the register file at that same edge. This is accepted behaviour.
- States: IDLE, ISSUE, CAPTURE, RESP.
- Grant logic (combinational, evaluated in IDLE only):
  - With FIXED_PRIO=1, requester 0 wins whenever req_valid[0] is high.
  - With FIXED_PRIO=0, a single requester wins alone. When both are valid, the winner is the requester not equal to last_grant.
  - req_ready = grant, and only in IDLE; it is 0 in all other states.
- IDLE, on an edge where the handshake completes:
  - Register the winner's fields onto the rf_* outputs.
  - rf_reg_write <= req_we, except it is forced to 0 when ZERO_REG=1 and the write address is 0.
  - Store the winner index in gnt_idx and update last_grant.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: the register file acts on the edge ending this cycle.
  - A write goes to RESP.
  - A read goes to CAPTURE.
  - rf_reg_write is cleared to 0 at this edge.
- CAPTURE: rf_read_data1/2 are valid.
  - Latch them into rsp_rdata1/2 at this edge. When ZERO_REG=1, substitute 0 for any read address equal to 0.
  - Go to RESP.
- RESP:
  - rsp_valid[gnt_idx] = 1 for exactly this cycle.
  - For a write, rsp_rdata1/2 read 0.
  - Go to IDLE. A new request can be granted at the next IDLE cycle.
- Latency from the accept edge to the rsp_valid cycle:
  - Read: 3 cycles.
  - Write: 2 cycles.
  - Throughput: one transaction per 4 cycles (read) or 3 cycles (write).
- rf_reg_write is high for at most one cycle per write and never during a read. This guarantees the register file's read branch executes.
- Requester inputs are ignored outside the accept edge, so they may change freely after acceptance.
- Responses carry no back-pressure; requesters must accept the rsp_valid pulse.

Test Plan:
- Reset, then requester 0 writes 0xDEADBEEF to r5 -> rf_reg_write high for 1 cycle with rf_write_reg=5; rsp_valid=2'b01 two cycles after accept.
- Requester 1 reads ra1=5, ra2=0 after the above -> rsp_valid=2'b10 three cycles after accept; rsp_rdata1=0xDEADBEEF, rsp_rdata2=0.
- Write 0x12345678 to r0 with ZERO_REG=1 -> rf_reg_write stays 0 and an ack is still given; a later read of r0 returns 0.
- Both requesters held valid for 6 consecutive reads, FIXED_PRIO=0 -> grants alternate 0,1,0,1,0,1. With FIXED_PRIO=1 -> requester 0 receives all 6 grants.
- rst_n pulsed low during CAPTURE -> no rsp_valid; all outputs 0 the next cycle; busy=0; the next request is granted normally.
- Back-to-back write r7=0xA5A5A5A5 then read r7 from the same requester -> read returns 0xA5A5A5A5 and busy stays high between transactions except for the single IDLE cycle.
